// File: rtl/counter_ctrl.sv
// counter_ctrl: Wishbone-mapped free-running counter with compare/IRQ
// and a shared load path arbitrated between Wishbone and the LA port.
module counter_ctrl #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [3:0]      wstrb,
  input  logic [1:0]      adr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            ready,
  input  logic            la_req,
  input  logic [BITS-1:0] la_val,
  output logic            la_gnt,
  output logic [BITS-1:0] count,
  output logic            running,
  output logic            irq
);

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_COUNT = 2'd1;
  localparam logic [1:0] A_CMP   = 2'd2;
  localparam logic [1:0] A_STAT  = 2'd3;

  localparam logic [BITS-1:0] ONE =
    {{(BITS-1){1'b0}}, 1'b1};

  logic [BITS-1:0] r_count;
  logic [BITS-1:0] r_cmp;
  logic            r_en;
  logic            r_per;
  logic            r_irqen;
  logic            r_match;
  logic            r_lawait;
  logic            r_ready;
  logic            r_lagnt;
  logic            r_last_la;
  logic [31:0]     r_rdata;

  logic            w_wr;
  logic            w_wb_pend;
  logic            w_cnt_pend;
  logic            w_la_pend;
  logic            w_conflict;
  logic            w_wb_win;
  logic            w_wb_acc;
  logic            w_wb_load;
  logic            w_la_load;
  logic            w_la_lose;
  logic            w_load;
  logic            w_cmp_ev;
  logic            w_ctrl_wr;
  logic            w_cmp_wr;
  logic            w_stat_wr;
  logic            w_clr_match;
  logic            w_clr_wait;
  logic [31:0]     w_cnt_ext;
  logic [31:0]     w_cmp_ext;
  logic [31:0]     w_cnt_mrg;
  logic [31:0]     w_cmp_mrg;
  logic [31:0]     w_rd;

  function automatic logic [31:0] f_ext(
    input logic [BITS-1:0] v
  );
    logic [31:0] r;
    r = '0;
    r[BITS-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] f_merge(
    input logic [31:0] o,
    input logic [3:0]  s,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  assign w_wr       = |wstrb;
  assign w_wb_pend  = valid & ~r_ready;
  assign w_cnt_pend = w_wb_pend & w_wr &
                      (adr == A_COUNT);
  assign w_la_pend  = la_req & ~r_lagnt;
  assign w_conflict = w_cnt_pend & w_la_pend;
  // WB wins a conflict when LA won the last one
  assign w_wb_win   = r_last_la;
  assign w_la_lose  = w_conflict & w_wb_win;
  assign w_wb_acc   = w_wb_pend &
                      ~(w_conflict & ~w_wb_win);
  assign w_la_load  = w_la_pend & ~w_la_lose;
  assign w_wb_load  = w_wb_acc & w_wr &
                      (adr == A_COUNT);
  assign w_load     = w_wb_load | w_la_load;

  assign w_ctrl_wr  = w_wb_acc & w_wr &
                      (adr == A_CTRL);
  assign w_cmp_wr   = w_wb_acc & w_wr &
                      (adr == A_CMP);
  assign w_stat_wr  = w_wb_acc & w_wr &
                      (adr == A_STAT);
  assign w_clr_match = w_stat_wr & wstrb[0] &
                       wdata[0];
  assign w_clr_wait  = w_stat_wr & wstrb[0] &
                       wdata[1];

  assign w_cmp_ev   = r_en & (r_count == r_cmp) &
                      ~w_load;

  assign w_cnt_ext  = f_ext(r_count);
  assign w_cmp_ext  = f_ext(r_cmp);
  assign w_cnt_mrg  = f_merge(w_cnt_ext, wstrb,
                              wdata);
  assign w_cmp_mrg  = f_merge(w_cmp_ext, wstrb,
                              wdata);

  // Read mux, zero-extended to the bus width
  always_comb begin
    w_rd = '0;
    case (adr)
      A_CTRL:  w_rd[2:0] = {r_irqen, r_per, r_en};
      A_COUNT: w_rd = w_cnt_ext;
      A_CMP:   w_rd = w_cmp_ext;
      A_STAT:  w_rd[1:0] = {r_lawait, r_match};
      default: w_rd = '0;
    endcase
  end

  // Handshake pulses and read capture at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_lagnt <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_wb_acc;
      r_lagnt <= w_la_load;
      if (w_wb_acc) r_rdata <= w_rd;
    end
  end

  // Round-robin history, moves only on conflicts
  always_ff @(posedge clk) begin
    if (reset) r_last_la <= 1'b1;
    else if (w_conflict) r_last_la <= ~w_wb_win;
  end

  // Counter: load, then compare event, then increment
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wb_load) begin
      r_count <= w_cnt_mrg[BITS-1:0];
    end else if (w_la_load) begin
      r_count <= la_val;
    end else if (w_cmp_ev) begin
      if (r_per) r_count <= '0;
    end else if (r_en) begin
      r_count <= r_count + ONE;
    end
  end

  // Control bits; a CTRL write beats one-shot stop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en    <= 1'b0;
      r_per   <= 1'b0;
      r_irqen <= 1'b0;
    end else if (w_ctrl_wr && wstrb[0]) begin
      r_en    <= wdata[0];
      r_per   <= wdata[1];
      r_irqen <= wdata[2];
    end else if (w_cmp_ev && !r_per) begin
      r_en    <= 1'b0;
    end
  end

  // Compare value, byte-writable
  always_ff @(posedge clk) begin
    if (reset) r_cmp <= '1;
    else if (w_cmp_wr) r_cmp <= w_cmp_mrg[BITS-1:0];
  end

  // Sticky status flags; setting beats clearing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_match  <= 1'b0;
      r_lawait <= 1'b0;
    end else begin
      r_match  <= w_cmp_ev |
                  (r_match & ~w_clr_match);
      r_lawait <= w_la_lose |
                  (r_lawait & ~w_clr_wait);
    end
  end

  assign rdata   = r_rdata;
  assign ready   = r_ready;
  assign la_gnt  = r_lagnt;
  assign count   = r_count;
  assign running = r_en;
  assign irq     = r_match & r_irqen;

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Wishbone-mapped controller that sequences a BITS-wide free-running counter and shares its load path between two requesters: the Wishbone slave port and the logic-analyzer (LA) load port.
- Provides enable, one-shot and periodic compare modes, a sticky match flag and an IRQ output.
- Sits between the user-project Wishbone/LA glue and the counter datapath, replacing ad-hoc load muxing.

Parameters:
- BITS, 32, counter/compare width (8..32); register reads zero-extend to 32 bits.

Ports:
- clk  input  1  single clock for all state
- reset  input  1  synchronous, active-high reset
- valid  input  1  Wishbone cyc&stb
- wstrb  input  4  byte write strobes (sel & we); all-zero means read
- adr  input  2  word offset (wbs_adr_i[3:2])
- wdata  input  32  write data
- rdata  output  32  read data, valid while ready=1
- ready  output  1  Wishbone ack, one-cycle pulse
- la_req  input  1  LA load request, level, held until la_gnt
- la_val  input  BITS  LA load value
- la_gnt  output  1  one-cycle pulse: la_val loaded this edge
- count  output  BITS  current counter value
- running  output  1  CTRL.EN
- irq  output  1  STATUS.MATCH & CTRL.IRQ_EN

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: count=0, CTRL=0, COMPARE=all-ones, STATUS=0, ready=0, rdata=0, la_gnt=0, last_grant=LA (so WB wins the first conflict).
- Register map (adr):
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN.
  - 1 COUNT: a write loads the counter.
  - 2 COMPARE.
  - 3 STATUS: bit0 MATCH, bit1 LA_WAIT (set when LA lost arbitration); both write-1-to-clear.
- Byte strobes apply per byte. Bits above BITS and undefined bits are ignored on write and read as 0.
- WB handshake:
  - A transaction is accepted on the edge where valid=1, ready=0 and it is not a stalled COUNT write.
  - ready=1 the following cycle for exactly one cycle; rdata is captured at acceptance.
  - Back-to-back accesses therefore take at least 2 cycles each.
- Counter update priority per edge (highest first):
  1. reset
  2. granted load (WB COUNT write or LA)
  3. compare event
  4. increment when EN=1
  5. hold
- Increment wraps modulo 2^BITS.
- Arbitration applies only when a WB COUNT write (any strobe set) and la_req are both pending on the same edge.
  - Grant goes to the requester that did not win the last conflict; last_grant updates only on conflicts.
  - Loser is stalled: WB gets no ready (master holds valid), LA gets no la_gnt (la_req held). Loser wins the next edge.
  - LA losing sets STATUS.LA_WAIT.
- Without a conflict, an LA request is granted the same edge: count<=la_val, la_gnt=1 next cycle. An LA load writes all bits.
- Non-COUNT WB accesses never conflict with LA and proceed in parallel with an LA grant.
- Compare event: EN=1, count==COMPARE, no load this edge.
  - PERIODIC=1: count<=0, MATCH<=1.
  - PERIODIC=0: count holds, EN<=0, MATCH<=1.
- Simultaneous MATCH set and W1C clear: set wins. Simultaneous CTRL write and one-shot EN clear: the CTRL write wins.
- A load with EN=0 updates count without starting it.
- A COMPARE write takes effect from the next edge's comparison.
- Reset mid-transaction: a pending ready or la_gnt is dropped. Requesters must re-issue after reset deasserts.
- COUNT read returns the value before this edge's update.

Test Plan:
- Reset, then read all four registers -> CTRL=0, COUNT=0, COMPARE=0xFFFFFFFF, STATUS=0; ready exactly 1 cycle after each valid.
- Write COMPARE=5, CTRL=0b111 (EN, PERIODIC, IRQ_EN) -> count sequence 0..5,0,1..; MATCH and irq rise on the edge count 5->0; W1C STATUS=1 clears irq; a clear coinciding with the next match leaves MATCH=1.
- One-shot: COMPARE=3, CTRL=0b001 -> count stops at 3, running=0, MATCH=1, irq=0 (IRQ_EN=0).
- Same-cycle WB COUNT write 0x100 and la_req with la_val 0x200 after reset -> WB wins (count=0x100, ready pulse), LA_WAIT=1, LA granted next edge (count=0x200, la_gnt pulse). Repeat the conflict -> LA wins first.
- Byte write to COUNT with wstrb=0010, wdata=0x0000AB00, from count 0x12345678 -> count 0x1234AB78; BITS=16 build: COUNT read upper half reads 0.
- Assert reset while ready/la_gnt are pending -> both 0 next cycle, all registers at reset values; increment from 0xFFFFFFFF with EN=1 and COMPARE=0 wraps to 0 with MATCH set only on the equality edge.
